// File: rtl/ternary_neuron_accum.sv
// ternary_neuron_accum
//   Accumulates the signed difference of two 3-bit popcounts (positive- and
//   negative-weight matches) over the beats of one ternary neuron. On the
//   last beat it thresholds the saturated sum into a ternary activation.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   beat handshake (in_ready low only while a result waits)
//   in_last             final beat of the neuron
//   pc_pos, pc_neg      unsigned popcounts 0..7
//   thr_hi, thr_lo      signed thresholds, sampled on the accepted last beat
//   out_valid/out_ready result handshake
//   out_act             01 = +1, 11 = -1, 00 = 0
//   out_sum             saturated signed final sum
//   out_beats           beats in this neuron (saturating count)
//   out_sat             accumulator clamped at least once during this neuron
module ternary_neuron_accum #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [2:0]              pc_pos,
  input  logic [2:0]              pc_neg,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    out_sat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sat_f;

  logic signed [ACC_W:0]   delta;
  logic signed [ACC_W:0]   sum_wide;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [1:0]              act_nxt;
  logic                    accept;

  // acc/cnt/sat_f are cleared whenever a neuron completes, so IDLE always
  // starts from zero and the same datapath serves the first beat.
  assign delta    = $signed({{(ACC_W-2){1'b0}}, pc_pos}) - $signed({{(ACC_W-2){1'b0}}, pc_neg});
  assign sum_wide = {acc[ACC_W-1], acc} + delta;
  // |delta| <= 7 keeps the ACC_W+1 sum exact; top two bits differing means
  // the result left the ACC_W range.
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign acc_nxt  = ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
  assign cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // +1 is tested first so a misconfigured thr_lo >= thr_hi resolves to +1.
  always_comb begin
    act_nxt = 2'b00;
    if (acc_nxt >= thr_hi)      act_nxt = 2'b01;
    else if (acc_nxt <= thr_lo) act_nxt = 2'b11;
  end

  assign in_ready  = (state != S_OUT);
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat_f     <= 1'b0;
      out_act   <= 2'b00;
      out_sum   <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_sum   <= acc_nxt;
              out_beats <= cnt_nxt;
              out_sat   <= sat_f | ovf;
              out_act   <= act_nxt;
              acc       <= '0;
              cnt       <= '0;
              sat_f     <= 1'b0;
              state     <= S_OUT;
            end else begin
              acc   <= acc_nxt;
              cnt   <= cnt_nxt;
              sat_f <= sat_f | ovf;
              state <= S_ACCUM;
            end
          end
        end
        S_OUT: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed bench for ternary_neuron_accum, built at ACC_W = 6 so that
// saturation is reachable with a handful of beats.
module tb_ternary_neuron_accum;
  localparam int ACC_W = 6;
  localparam int CNT_W = 6;

  logic                    clk = 1'b0;
  logic                    rst, in_valid, in_last, out_ready;
  logic                    in_ready, out_valid, out_sat;
  logic [2:0]              pc_pos, pc_neg;
  logic signed [ACC_W-1:0] thr_hi, thr_lo, out_sum;
  logic [1:0]              out_act;
  logic [CNT_W-1:0]        out_beats;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ternary_neuron_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .pc_pos(pc_pos), .pc_neg(pc_neg),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(out_valid),
    .out_ready(out_ready), .out_act(out_act), .out_sum(out_sum),
    .out_beats(out_beats), .out_sat(out_sat)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int p, input int n, input bit last, input int hi, input int lo);
    chk("in_ready_before_beat", int'(in_ready), 1);
    in_valid = 1'b1;
    pc_pos   = p[2:0];
    pc_neg   = n[2:0];
    in_last  = last;
    thr_hi   = hi[ACC_W-1:0];
    thr_lo   = lo[ACC_W-1:0];
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    pc_pos   = 3'd0;
    pc_neg   = 3'd0;
  endtask

  // Called right after the last beat: result must be valid now, then
  // handshake (out_ready = 1) and in_ready must return the next cycle.
  task automatic expect_res(input string tag, input int sum, input int act,
                            input int beats, input int sat);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_sum"},   int'(out_sum), sum);
    chk({tag, "_act"},   int'(out_act), act);
    chk({tag, "_beats"}, int'(out_beats), beats);
    chk({tag, "_sat"},   int'(out_sat), sat);
    chk({tag, "_ready_in_out"}, int'(in_ready), 0);
    tick();
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    pc_pos = 3'd0; pc_neg = 3'd0; thr_hi = '0; thr_lo = '0;

    // Reset held 2 cycles with beats offered
    for (int i = 0; i < 2; i++) begin
      pc_pos  = 3'($urandom_range(0, 7));
      pc_neg  = 3'($urandom_range(0, 7));
      in_last = 1'($urandom_range(0, 1));
      tick();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_act",   int'(out_act), 0);
      chk("rst_out_sum",   int'(out_sum), 0);
      chk("rst_out_beats", int'(out_beats), 0);
      chk("rst_out_sat",   int'(out_sat), 0);
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_idle_valid", int'(out_valid), 0);

    // Three-beat positive neuron: 5 + 2 - 2 = 5
    beat(5, 0, 0, 4, -4);
    beat(3, 1, 0, 4, -4);
    beat(0, 2, 1, 4, -4);
    expect_res("pos3", 5, 1, 3, 0);

    // Single-beat negative, then zero
    beat(0, 5, 1, 3, -3);
    expect_res("neg1", -5, 3, 1, 0);
    beat(2, 2, 1, 3, -3);
    expect_res("zero1", 0, 0, 1, 0);

    // Positive saturation: 6 x 7 = 42 -> 31
    for (int i = 0; i < 6; i++) beat(7, 0, (i == 5), 10, -10);
    expect_res("satpos", 31, 1, 6, 1);
    beat(1, 0, 1, 10, -10);
    expect_res("after_sat", 1, 0, 1, 0);

    // Negative saturation: 10 x -7 -> -32
    for (int i = 0; i < 10; i++) beat(0, 7, (i == 9), 0, -5);
    expect_res("satneg", -32, 3, 10, 1);

    // Clamp then recover: 31 after clamp, -7 on last -> 24, sat sticky
    for (int i = 0; i < 5; i++) beat(7, 0, 0, 30, -30);
    beat(0, 7, 1, 30, -30);
    expect_res("sat_sticky", 24, 0, 6, 1);

    // Threshold boundaries and misconfigured thresholds (+1 wins)
    beat(4, 0, 1, 4, -4);
    expect_res("eq_hi", 4, 1, 1, 0);
    beat(0, 4, 1, 5, -4);
    expect_res("eq_lo", -4, 3, 1, 0);
    beat(3, 0, 1, 2, 5);
    expect_res("misconf", 3, 1, 1, 0);

    // Beat counter saturates at 63
    for (int i = 0; i < 65; i++) beat(0, 0, (i == 64), 1, -1);
    expect_res("cnt_sat", 0, 0, 63, 0);

    // Backpressure: result held, no beat absorbed
    out_ready = 1'b0;
    beat(2, 0, 1, 1, -1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_last = 1'b1;
      pc_pos = 3'(7 - i); pc_neg = 3'(i);
      tick();
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_valid",    int'(out_valid), 1);
      chk("bp_sum",      int'(out_sum), 2);
      chk("bp_act",      int'(out_act), 1);
      chk("bp_beats",    int'(out_beats), 1);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", int'(out_valid), 0);
    chk("bp_ready_back", int'(in_ready), 1);
    beat(1, 0, 1, 4, -4);
    expect_res("bp_next", 1, 0, 1, 0);

    // Mid-neuron reset discards partial sum
    beat(4, 0, 0, 4, -4);
    beat(4, 0, 0, 4, -4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(in_ready), 1);
    beat(1, 0, 1, 4, -4);
    expect_res("midrst", 1, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
